// File: rtl/map_bank_irq_if.sv
// Cartridge-side bus bundle for the indexed bank mapper: CPU/PPU address inputs,
// save-state access and the mapped PRG/CHR/CIRAM/IRQ outputs.
interface map_bank_irq_if #(
    parameter int PRG_AW = 19,
    parameter int CHR_AW = 18
);
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_dat;
    logic              cpu_we;
    logic [13:0]       ppu_addr;
    logic              ss_act;
    logic              ss_we;
    logic [7:0]        ss_addr;
    logic [7:0]        ss_rdat;
    logic [PRG_AW-1:0] prg_addr;
    logic [CHR_AW-1:0] chr_addr;
    logic              ciram_a10;
    logic              irq;

    modport master (
        output cpu_addr, cpu_dat, cpu_we, ppu_addr, ss_act, ss_we, ss_addr,
        input  ss_rdat, prg_addr, chr_addr, ciram_a10, irq
    );

    modport slave (
        input  cpu_addr, cpu_dat, cpu_we, ppu_addr, ss_act, ss_we, ss_addr,
        output ss_rdat, prg_addr, chr_addr, ciram_a10, irq
    );
endinterface

// File: rtl/map_bank_irq.sv
// Indexed bank-register mapper (index at $8000, data at $A000) with selectable
// PRG/CHR slot layout, four mirroring modes and a CPU-cycle IRQ down-counter.
module map_bank_irq #(
    parameter int PRG_SLOTS = 2,
    parameter int CHR_MODE  = 0,
    parameter int PRG_AW    = 19,
    parameter int CHR_AW    = 18,
    parameter int MAP_IDX   = 112
) (
    input  logic          m2,
    input  logic          rst_n,
    map_bank_irq_if.slave bus
);
    localparam int         PRG_BW = PRG_AW - 13;
    localparam int         CHR_BW = CHR_AW - 10;
    localparam int         N_CHR  = (CHR_MODE == 0) ? 6 : 8;
    localparam logic [3:0] PRG_N  = 4'(PRG_SLOTS);
    localparam logic [3:0] CHR_N  = 4'(N_CHR);
    localparam logic [7:0] MAP_ID = 8'(MAP_IDX);

    logic [PRG_BW-1:0] prg_q [4];
    logic [PRG_BW-1:0] prg_d [4];
    logic [CHR_BW-1:0] chr_q [8];
    logic [CHR_BW-1:0] chr_d [8];
    logic [3:0]        idx_q, idx_d;
    logic [1:0]        mirror_q, mirror_d;
    logic [15:0]       latch_q, latch_d;
    logic [15:0]       ctr_q, ctr_d;
    logic              irq_en_q, irq_en_d;
    logic              auto_q, auto_d;
    logic              irq_q, irq_d;

    logic [3:0]        sel;
    logic [3:0]        cidx;
    logic [1:0]        win, win_rev;
    logic [PRG_BW-1:0] prg_bank;
    logic [2:0]        cslot;
    logic [CHR_BW-1:0] chr_bank;

    assign sel  = {bus.cpu_addr[15:13], bus.cpu_addr[0]};
    assign cidx = idx_q - PRG_N;

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) prg_q[i] <= '0;
            for (int i = 0; i < 8; i++) chr_q[i] <= '0;
            idx_q    <= '0;
            mirror_q <= '0;
            latch_q  <= '0;
            ctr_q    <= '0;
            irq_en_q <= 1'b0;
            auto_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            prg_q    <= prg_d;
            chr_q    <= chr_d;
            idx_q    <= idx_d;
            mirror_q <= mirror_d;
            latch_q  <= latch_d;
            ctr_q    <= ctr_d;
            irq_en_q <= irq_en_d;
            auto_q   <= auto_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        prg_d    = prg_q;
        chr_d    = chr_q;
        idx_d    = idx_q;
        mirror_d = mirror_q;
        latch_d  = latch_q;
        ctr_d    = ctr_q;
        irq_en_d = irq_en_q;
        auto_d   = auto_q;
        irq_d    = irq_q;
        if (bus.ss_act) begin
            if (bus.ss_we) begin
                case (bus.ss_addr) inside
                    [8'd0:8'd2]: begin
                        if ({2'b00, bus.ss_addr[1:0]} < PRG_N)
                            prg_d[bus.ss_addr[1:0]] = bus.cpu_dat[PRG_BW-1:0];
                    end
                    [8'd8:8'd15]: begin
                        if ({1'b0, bus.ss_addr[2:0]} < CHR_N)
                            chr_d[bus.ss_addr[2:0]] = bus.cpu_dat[CHR_BW-1:0];
                    end
                    8'd16: begin
                        idx_d    = bus.cpu_dat[7:4];
                        mirror_d = bus.cpu_dat[1:0];
                    end
                    8'd17: latch_d[7:0]  = bus.cpu_dat;
                    8'd18: latch_d[15:8] = bus.cpu_dat;
                    8'd19: begin
                        irq_en_d = bus.cpu_dat[0];
                        auto_d   = bus.cpu_dat[1];
                        irq_d    = bus.cpu_dat[2];
                    end
                    8'd20: ctr_d[7:0]  = bus.cpu_dat;
                    8'd21: ctr_d[15:8] = bus.cpu_dat;
                    default: ;
                endcase
            end
        end else begin
            if (irq_en_q) begin
                if (ctr_q != 16'd0) begin
                    ctr_d = ctr_q - 16'd1;
                end else begin
                    irq_d = 1'b1;
                    if (auto_q) ctr_d = latch_q;
                    else        irq_en_d = 1'b0;
                end
            end
            // A CPU write lands after the countdown so an $E001 write overrides a same-cycle expiry.
            if (bus.cpu_we) begin
                case (sel)
                    4'b1000: idx_d = bus.cpu_dat[3:0];
                    4'b1010: begin
                        if (idx_q < PRG_N)
                            prg_d[idx_q[1:0]] = bus.cpu_dat[PRG_BW-1:0];
                        else if (cidx < CHR_N)
                            chr_d[cidx[2:0]] = bus.cpu_dat[CHR_BW-1:0];
                    end
                    4'b1100: latch_d[7:0]  = bus.cpu_dat;
                    4'b1101: latch_d[15:8] = bus.cpu_dat;
                    4'b1110: mirror_d = bus.cpu_dat[1:0];
                    4'b1111: begin
                        irq_en_d = bus.cpu_dat[0];
                        auto_d   = bus.cpu_dat[1];
                        irq_d    = 1'b0;
                        if (bus.cpu_dat[0]) ctr_d = latch_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Windows past the switchable ones count back from the last bank, so $E000 is always the last bank.
    always_comb begin
        win     = bus.cpu_addr[14:13];
        win_rev = 2'd3 - win;
        if ({2'b00, win} < PRG_N) prg_bank = prg_q[win];
        else                      prg_bank = {PRG_BW{1'b1}} - PRG_BW'(win_rev);
    end

    always_comb begin
        if (CHR_MODE == 0) begin
            if (!bus.ppu_addr[12]) cslot = {2'b00, bus.ppu_addr[11]};
            else                   cslot = {1'b0, bus.ppu_addr[11:10]} + 3'd2;
        end else begin
            cslot = bus.ppu_addr[12:10];
        end
        chr_bank = chr_q[cslot];
        if (CHR_MODE == 0 && !bus.ppu_addr[12]) chr_bank[0] = bus.ppu_addr[10];
    end

    always_comb begin
        bus.ciram_a10 = bus.ppu_addr[10];
        case (mirror_q)
            2'd0: bus.ciram_a10 = bus.ppu_addr[10];
            2'd1: bus.ciram_a10 = bus.ppu_addr[11];
            2'd2: bus.ciram_a10 = 1'b0;
            2'd3: bus.ciram_a10 = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bus.ss_rdat = 8'hFF;
        case (bus.ss_addr) inside
            [8'd0:8'd2]:  bus.ss_rdat = 8'(prg_q[bus.ss_addr[1:0]]);
            [8'd8:8'd15]: bus.ss_rdat = 8'(chr_q[bus.ss_addr[2:0]]);
            8'd16:   bus.ss_rdat = {idx_q, 2'b00, mirror_q};
            8'd17:   bus.ss_rdat = latch_q[7:0];
            8'd18:   bus.ss_rdat = latch_q[15:8];
            8'd19:   bus.ss_rdat = {5'b00000, irq_q, auto_q, irq_en_q};
            8'd20:   bus.ss_rdat = ctr_q[7:0];
            8'd21:   bus.ss_rdat = ctr_q[15:8];
            8'd127:  bus.ss_rdat = MAP_ID;
            default: bus.ss_rdat = 8'hFF;
        endcase
    end

    assign bus.prg_addr = {prg_bank, bus.cpu_addr[12:0]};
    assign bus.chr_addr = {chr_bank, bus.ppu_addr[9:0]};
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_map_bank_irq.sv
// Directed bench for map_bank_irq (PRG_SLOTS=2, CHR_MODE=0, PRG_AW=19, CHR_AW=18):
// bank mapping, mirroring, IRQ counter timing and save-state access.
module tb_map_bank_irq;
    logic m2;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    map_bank_irq_if #(.PRG_AW(19), .CHR_AW(18)) bus ();

    map_bank_irq #(
        .PRG_SLOTS(2), .CHR_MODE(0), .PRG_AW(19), .CHR_AW(18), .MAP_IDX(112)
    ) dut (
        .m2   (m2),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial m2 = 1'b0;
    always #10 m2 = ~m2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called during the low phase; returns on the negedge after the write edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr = a;
        bus.cpu_dat  = d;
        bus.cpu_we   = 1'b1;
        @(negedge m2);
        bus.cpu_we   = 1'b0;
    endtask

    task automatic ss_write(input logic [7:0] a, input logic [7:0] d);
        bus.ss_addr = a;
        bus.cpu_dat = d;
        bus.ss_we   = 1'b1;
        @(negedge m2);
        bus.ss_we   = 1'b0;
    endtask

    task automatic ss_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.ss_addr = a;
        #1;
        chk(tag, 32'(bus.ss_rdat), 32'(exp));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge m2);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.cpu_addr = 16'hE000;
        bus.cpu_dat  = 8'h00;
        bus.cpu_we   = 1'b0;
        bus.ppu_addr = 14'h0000;
        bus.ss_act   = 1'b0;
        bus.ss_we    = 1'b0;
        bus.ss_addr  = 8'd0;

        // Reset state
        #25;
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_prg_E000", 32'(bus.prg_addr[18:13]), 32'h3F);
        bus.cpu_addr = 16'h8000; #1;
        chk("rst_prg_8000", 32'(bus.prg_addr[18:13]), 32'h00);
        bus.cpu_addr = 16'hC000; #1;
        chk("rst_prg_C000", 32'(bus.prg_addr[18:13]), 32'h3E);
        ss_chk("rst_ctr", 8'd20, 8'h00);
        @(negedge m2);
        rst_n = 1'b1;
        tick(1);

        // PRG banking
        cpu_write(16'h8000, 8'h01);
        cpu_write(16'hA000, 8'h05);
        bus.cpu_addr = 16'hA123; #1;
        chk("prg_A123", 32'(bus.prg_addr), 32'h0A123);
        bus.cpu_addr = 16'hE456; #1;
        chk("prg_E456_last", 32'(bus.prg_addr), 32'h7E456);

        // Out-of-range index writes leave every bank register alone
        cpu_write(16'h8000, 8'h09);
        cpu_write(16'hA000, 8'h55);
        cpu_write(16'h8000, 8'h08);
        cpu_write(16'hA000, 8'h66);
        ss_chk("idx_prg0", 8'd0, 8'h00);
        ss_chk("idx_prg1", 8'd1, 8'h05);
        ss_chk("idx_prg2", 8'd2, 8'h00);
        ss_chk("idx_chr5", 8'd13, 8'h00);
        ss_chk("idx_chr6", 8'd14, 8'h00);
        ss_chk("idx_chr7", 8'd15, 8'h00);
        tick(1);

        // CHR banking: 2K slot 0 and 1K slot 3
        cpu_write(16'h8000, 8'h02);
        cpu_write(16'hA000, 8'h07);
        bus.ppu_addr = 14'h0400; #1;
        chk("chr_0400", 32'(bus.chr_addr[17:10]), 32'h07);
        bus.ppu_addr = 14'h0000; #1;
        chk("chr_0000", 32'(bus.chr_addr), 32'h01800);
        cpu_write(16'h8000, 8'h05);
        cpu_write(16'hA000, 8'h9A);
        bus.ppu_addr = 14'h1403; #1;
        chk("chr_1403", 32'(bus.chr_addr), 32'h26803);
        tick(1);

        // Mirroring modes
        bus.ppu_addr = 14'h0400; #1;
        chk("mir0_0400", 32'(bus.ciram_a10), 32'h1);
        bus.ppu_addr = 14'h0800; #1;
        chk("mir0_0800", 32'(bus.ciram_a10), 32'h0);
        cpu_write(16'hE000, 8'h01);
        chk("mir1_0800", 32'(bus.ciram_a10), 32'h1);
        bus.ppu_addr = 14'h0400; #1;
        chk("mir1_0400", 32'(bus.ciram_a10), 32'h0);
        cpu_write(16'hE000, 8'h02);
        bus.ppu_addr = 14'h0C00; #1;
        chk("mir2_0C00", 32'(bus.ciram_a10), 32'h0);
        cpu_write(16'hE000, 8'h03);
        bus.ppu_addr = 14'h0000; #1;
        chk("mir3_0000", 32'(bus.ciram_a10), 32'h1);
        ss_chk("ss_idx_mir", 8'd16, 8'h53);
        tick(1);

        // One-shot IRQ: latch 3 fires on the 4th edge after the enabling write
        cpu_write(16'hC000, 8'h03);
        cpu_write(16'hC001, 8'h00);
        cpu_write(16'hE001, 8'h01);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk($sformatf("os_irq_low_%0d", i), 32'(bus.irq), 32'h0);
        end
        tick(1);
        chk("os_irq_fire", 32'(bus.irq), 32'h1);
        ss_chk("os_status", 8'd19, 8'h04);
        ss_chk("os_ctr0", 8'd20, 8'h00);
        tick(2);
        chk("os_irq_hold", 32'(bus.irq), 32'h1);
        ss_chk("os_ctr_stop", 8'd20, 8'h00);
        cpu_write(16'hE001, 8'h00);
        chk("os_ack", 32'(bus.irq), 32'h0);
        tick(1);

        // Auto-reload IRQ and an ack coincident with expiry
        cpu_write(16'hC000, 8'h02);
        cpu_write(16'hE001, 8'h03);
        tick(2);
        chk("ar_irq_low", 32'(bus.irq), 32'h0);
        tick(1);
        chk("ar_irq_fire", 32'(bus.irq), 32'h1);
        ss_chk("ar_reload", 8'd20, 8'h02);
        tick(2);
        cpu_write(16'hE001, 8'h03);
        chk("ar_ack_wins", 32'(bus.irq), 32'h0);
        ss_chk("ar_ctr_reload", 8'd20, 8'h02);
        ss_chk("ar_status", 8'd19, 8'h03);
        tick(1);
        ss_chk("ar_ctr_next", 8'd20, 8'h01);
        cpu_write(16'hE001, 8'h00);
        tick(1);

        // Save-state mode: CPU writes ignored, counter frozen
        cpu_write(16'hE001, 8'h01);
        bus.ss_act = 1'b1;
        cpu_write(16'hA000, 8'h11);
        tick(2);
        ss_chk("ss_cpu_wr_ignored", 8'd11, 8'h9A);
        ss_chk("ss_ctr_frozen", 8'd20, 8'h02);
        ss_write(8'd20, 8'h10);
        ss_chk("ss_ctr_lo", 8'd20, 8'h10);
        ss_chk("ss_ctr_hi", 8'd21, 8'h00);
        ss_chk("ss_map_idx", 8'd127, 8'd112);
        ss_chk("ss_unmapped", 8'd50, 8'hFF);
        tick(1);
        ss_write(8'd9, 8'hAB);
        ss_chk("ss_chr1", 8'd9, 8'hAB);
        ss_write(8'd15, 8'h77);
        ss_chk("ss_chr7_absent", 8'd15, 8'h00);
        ss_write(8'd19, 8'h07);
        ss_chk("ss_status", 8'd19, 8'h07);
        chk("ss_irq_out", 32'(bus.irq), 32'h1);
        tick(1);
        bus.ss_act = 1'b0;
        tick(1);
        ss_chk("ss_resume", 8'd20, 8'h0F);
        chk("ss_resume_irq", 32'(bus.irq), 32'h1);

        // Asynchronous reset mid-count
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_irq", 32'(bus.irq), 32'h0);
        ss_chk("arst_ctr", 8'd20, 8'h00);
        ss_chk("arst_status", 8'd19, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
